// File: rtl/tm1638_key_conditioner.sv
// tm1638_key_conditioner: synchronises and debounces the TM1638 key inputs, then
// derives one-cycle press/release pulses, per-key toggle latches, a wrapping press
// counter and the index of the most recently pressed key.
// Optional feature macro: AUTOREPEAT_EN (held-key auto-repeat on last_key).
module tm1638_key_conditioner #(
  parameter int N_KEYS          = 8,
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int W_COUNT         = 16,
  parameter int REPEAT_DELAY    = 13500000,
  parameter int REPEAT_PERIOD   = 2700000,
  localparam int IDX_W          = (N_KEYS > 1) ? $clog2(N_KEYS) : 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [N_KEYS-1:0]  key_raw,
  output logic [N_KEYS-1:0]  key_stable,
  output logic [N_KEYS-1:0]  key_press,
  output logic [N_KEYS-1:0]  key_release,
  output logic [N_KEYS-1:0]  key_toggle,
  output logic [W_COUNT-1:0] press_count,
  output logic [IDX_W-1:0]   last_key,
  output logic               any_pressed
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("tm1638_key_conditioner: invalid timing parameters");
  end

  // Number of set bits, truncated to the counter width so the sum wraps naturally.
  function automatic logic [W_COUNT-1:0] popcount(input logic [N_KEYS-1:0] v);
    logic [W_COUNT-1:0] s;
    s = '0;
    for (int i = 0; i < N_KEYS; i++) s = s + W_COUNT'(v[i]);
    return s;
  endfunction

  // Lowest set index of v, or hold when v is empty.
  function automatic logic [IDX_W-1:0] lowest_index(input logic [N_KEYS-1:0] v,
                                                    input logic [IDX_W-1:0]  hold);
    logic [IDX_W-1:0] r;
    r = hold;
    for (int i = N_KEYS - 1; i >= 0; i--) if (v[i]) r = IDX_W'(i);
    return r;
  endfunction

  logic [N_KEYS-1:0] sync_p0, sync_p1;
  logic [N_KEYS-1:0] stable_p3;
  logic [CNT_W-1:0]  cnt [N_KEYS];
  logic [N_KEYS-1:0] rise, fall, press_next;

  // Stage 0/1: two-flop synchroniser, sync_p1 is the usable level.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= key_raw;
      sync_p1 <= sync_p0;
    end
  end

  // Stage 2: accept a level only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clock) begin
    if (reset) begin
      key_stable <= '0;
      for (int i = 0; i < N_KEYS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_KEYS; i++) begin
        if (sync_p1[i] == key_stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          key_stable[i] <= sync_p1[i];
          cnt[i]        <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign rise        = key_stable & ~stable_p3;
  assign fall        = ~key_stable & stable_p3;
  assign any_pressed = |key_stable;

`ifdef AUTOREPEAT_EN
  localparam int RMAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TMR_W = $clog2(RMAX + 1);

  logic [TMR_W-1:0] rep_tmr;
  logic             rep_run;
  logic             rep_act;
  logic [IDX_W-1:0] rep_key;
  logic             rep_fire;

  // rep_key mirrors last_key but is updated in the same cycle as the press pulse.
  assign rep_fire   = rep_act && key_stable[rep_key] &&
                      (rep_run ? (rep_tmr == TMR_W'(REPEAT_PERIOD - 1))
                               : (rep_tmr == TMR_W'(REPEAT_DELAY - 1)));
  assign press_next = rise | (rep_fire ? (N_KEYS'(1) << rep_key) : '0);

  // Repeat timer: restarts on every real press, dies when the tracked key is released.
  always_ff @(posedge clock) begin
    if (reset) begin
      rep_tmr <= '0;
      rep_run <= 1'b0;
      rep_act <= 1'b0;
      rep_key <= '0;
    end else if (rise != '0) begin
      rep_tmr <= '0;
      rep_run <= 1'b0;
      rep_act <= 1'b1;
      rep_key <= lowest_index(press_next, rep_key);
    end else if (!rep_act || !key_stable[rep_key]) begin
      rep_tmr <= '0;
      rep_run <= 1'b0;
      rep_act <= 1'b0;
    end else if (rep_fire) begin
      rep_tmr <= '0;
      rep_run <= 1'b1;
    end else begin
      rep_tmr <= rep_tmr + 1'b1;
    end
  end
`else
  assign press_next = rise;
`endif

  // Stage 3: edge detection on the debounced level, one-cycle pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      stable_p3   <= '0;
      key_press   <= '0;
      key_release <= '0;
    end else begin
      stable_p3   <= key_stable;
      key_press   <= press_next;
      key_release <= fall;
    end
  end

  // Stage 4: toggle latches, press counter and last pressed key follow key_press.
  always_ff @(posedge clock) begin
    if (reset) begin
      key_toggle  <= '0;
      press_count <= '0;
      last_key    <= '0;
    end else begin
      key_toggle  <= key_toggle ^ key_press;
      press_count <= press_count + popcount(key_press);
      last_key    <= lowest_index(key_press, last_key);
    end
  end

endmodule

// File: tb/tb_tm1638_key_conditioner.sv
// Bench for tm1638_key_conditioner: a history-based reference model checked every
// cycle, plus hand-computed expectations for the key scenarios.
module tb_tm1638_key_conditioner;
  localparam int N  = 8;
  localparam int D  = 4;
  localparam int W  = 4;
  localparam int RD = 10;
  localparam int RP = 3;
  localparam int MAXC = 2048;

  logic         clock = 1'b0;
  logic         reset;
  logic [N-1:0] key_raw;
  logic [N-1:0] key_stable, key_press, key_release, key_toggle;
  logic [W-1:0] press_count;
  logic [2:0]   last_key;
  logic         any_pressed;

  int checks = 0;
  int errors = 0;

  tm1638_key_conditioner #(
    .N_KEYS(N), .DEBOUNCE_CYCLES(D), .W_COUNT(W),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clock(clock), .reset(reset), .key_raw(key_raw),
    .key_stable(key_stable), .key_press(key_press), .key_release(key_release),
    .key_toggle(key_toggle), .press_count(press_count), .last_key(last_key),
    .any_pressed(any_pressed)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [N-1:0] raw_h  [0:MAXC-1];
  logic [N-1:0] stab_h [0:MAXC-1];
  bit           rst_h  [0:MAXC-1];
  int           n = 0;

  logic [N-1:0] m_stable = '0, m_press = '0, m_release = '0, m_toggle = '0;
  logic [W-1:0] m_count = '0;
  logic [2:0]   m_last = '0;
  bit           alive = 1'b0;
  int           r_p = -1;
  logic [2:0]   r_key = '0;

  // Synchronised level seen by the debouncer at edge k: the raw level two edges
  // earlier, or zero while the synchroniser is refilling after reset.
  function automatic logic [N-1:0] samp(input int k);
    if (k < 2) return '0;
    if (rst_h[k-1] || rst_h[k-2]) return '0;
    return raw_h[k-2];
  endfunction

  function automatic logic [2:0] lowest(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return 3'(i);
    return 3'd0;
  endfunction

  always @(posedge clock) begin : model
    logic [N-1:0] stb1, stb2, newp, acc, s;
    bit fire;
    raw_h[n] = key_raw;
    rst_h[n] = reset;
    if (reset) begin
      m_stable = '0; m_press = '0; m_release = '0; m_toggle = '0;
      m_count = '0; m_last = '0; alive = 1'b0; r_p = -1; r_key = '0;
      stab_h[n] = '0;
    end else begin
      stb1 = (n >= 1) ? stab_h[n-1] : '0;
      stb2 = (n >= 2 && !rst_h[n-1]) ? stab_h[n-2] : '0;
      newp = stb1 & ~stb2;
`ifdef AUTOREPEAT_EN
      fire = alive && stb1[r_key] &&
             ((n - r_p == RD) || ((n - r_p > RD) && ((n - r_p - RD) % RP == 0)));
      if (fire) newp[r_key] = 1'b1;
      if ((stb1 & ~stb2) != '0) begin
        r_p = n; r_key = lowest(newp); alive = 1'b1;
      end else if (!stb1[r_key]) begin
        alive = 1'b0;
      end
`else
      fire = 1'b0;
`endif
      m_toggle = m_toggle ^ m_press;
      m_count  = m_count + W'($countones(m_press));
      if (m_press != '0) m_last = lowest(m_press);
      m_press   = newp;
      m_release = ~stb1 & stb2;
      acc = '0;
      for (int i = 0; i < N; i++) begin
        acc[i] = 1'b1;
        for (int j = 0; j < D; j++) begin
          if (n - j < 0) acc[i] = 1'b0;
          else if (rst_h[n-j]) acc[i] = 1'b0;
          else begin
            s = samp(n - j);
            if (s[i] == stb1[i]) acc[i] = 1'b0;
          end
        end
      end
      m_stable  = stb1 ^ acc;
      stab_h[n] = m_stable;
    end
    n++;
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (n > 0) begin
      chk("cyc_stable",  32'(key_stable),  32'(m_stable));
      chk("cyc_press",   32'(key_press),   32'(m_press));
      chk("cyc_release", 32'(key_release), 32'(m_release));
      chk("cyc_toggle",  32'(key_toggle),  32'(m_toggle));
      chk("cyc_count",   32'(press_count), 32'(m_count));
      chk("cyc_last",    32'(last_key),    32'(m_last));
      chk("cyc_any",     32'(any_pressed), 32'(|m_stable));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    reset = 1'b1;
    key_raw = '0;
    repeat (3) tick();
    chk("rst_stable", 32'(key_stable), 0);
    chk("rst_count",  32'(press_count), 0);
    chk("rst_toggle", 32'(key_toggle), 0);
    chk("rst_last",   32'(last_key), 0);
    chk("rst_any",    32'(any_pressed), 0);

    // Key 0 held from the first edge after reset.
    reset = 1'b0;
    key_raw = 8'h01;
    repeat (5) tick();
    chk("k0_stable_e5", 32'(key_stable[0]), 0);
    tick();
    chk("k0_stable_e6", 32'(key_stable[0]), 1);
    chk("k0_press_e6",  32'(key_press), 0);
    tick();
    chk("k0_press_e7",  32'(key_press), 32'h01);
    chk("k0_count_e7",  32'(press_count), 0);
    tick();
    chk("k0_press_e8",  32'(key_press), 0);
    chk("k0_toggle",    32'(key_toggle), 32'h01);
    chk("k0_count",     32'(press_count), 1);
    chk("k0_last",      32'(last_key), 0);
    chk("k0_any",       32'(any_pressed), 1);
    key_raw = '0;
    repeat (12) tick();
    chk("k0_released", 32'(any_pressed), 0);

    // Three-cycle glitch on key 3 must be discarded.
    key_raw = 8'h08;
    repeat (3) tick();
    key_raw = '0;
    repeat (12) tick();
    chk("glitch_stable", 32'(key_stable), 0);
    chk("glitch_count",  32'(press_count), 1);

    // Keys 2 and 5 together.
    key_raw = 8'h24;
    repeat (7) tick();
    chk("dual_press", 32'(key_press), 32'h24);
    tick();
    chk("dual_count",  32'(press_count), 3);
    chk("dual_last",   32'(last_key), 2);
    chk("dual_toggle", 32'(key_toggle), 32'h25);
    key_raw = '0;
    repeat (12) tick();

    // Fresh start, then 17 clean presses of key 1: counter wraps to 1.
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    for (int p = 0; p < 17; p++) begin
      key_raw = 8'h02;
      repeat (8) tick();
      key_raw = '0;
      repeat (8) tick();
    end
    chk("wrap_count",  32'(press_count), 1);
    chk("wrap_toggle", 32'(key_toggle), 32'h02);
    chk("wrap_last",   32'(last_key), 1);

    // Reset in the middle of key 4's debounce.
    key_raw = 8'h10;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    chk("mid_rst_stable", 32'(key_stable), 0);
    chk("mid_rst_toggle", 32'(key_toggle), 0);
    chk("mid_rst_count",  32'(press_count), 0);
    tick();
    reset = 1'b0;
    repeat (6) tick();
    chk("mid_rst_press_e6", 32'(key_press), 0);
    tick();
    chk("mid_rst_press_e7", 32'(key_press), 32'h10);
    tick();
    chk("mid_rst_count_after", 32'(press_count), 1);
    key_raw = '0;
    repeat (12) tick();

    // Long hold of key 6.
    key_raw = 8'h40;
    repeat (40) tick();
    key_raw = '0;
    repeat (14) tick();
`ifdef AUTOREPEAT_EN
    chk("hold6_count", 32'(press_count), 12);
`else
    chk("hold6_count", 32'(press_count), 2);
`endif
    chk("hold6_toggle", 32'(key_toggle), 32'h50);
    chk("hold6_last",   32'(last_key), 6);
    chk("hold6_any",    32'(any_pressed), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
